cache_bank_input_arb: RTL and testbench
=======================================

// Module: cache_bank_input_arb
// PURPOSE
// - Input stage of a cache bank; sits directly in front of the bank pipeline and the bank MSHR.
// - Arbitrates three request sources into one registered pipeline request per cycle:
//   - memory fill responses;
//   - MSHR replays (dequeue);
//   - new core requests.
// - Fill address comes from the MSHR lookup (fill_addr indexed by fill_id).
// - Core requests are throttled by MSHR almost-full back-pressure.
// PARAMETERS
// - LINE_ADDR_W   26  line address width (matches the bank's CS_LINE_ADDR_WIDTH)
// - WORD_W        32  core/replay write-data width
// - LINE_W        512 fill line-data width; LINE_W >= WORD_W
// - MSHR_ADDR_W   2   MSHR slot id width
// - STARVE_MAX    8   consecutive denied core cycles before core is forced to win; >= 1
// - PERF_CTR_W    32  performance counter width (CS_ARB_PERF_EN only)
// PORTS
// - clk               in  1            clock
// - reset             in  1            synchronous, active-high
// - core_req_valid    in  1            core request valid
// - core_req_addr     in  LINE_ADDR_W  core line address
// - core_req_rw       in  1            1 = write
// - core_req_data     in  WORD_W       core write data
// - core_req_ready    out 1            core request accepted this cycle
// - replay_valid      in  1            MSHR dequeue valid
// - replay_addr       in  LINE_ADDR_W  replay line address
// - replay_rw         in  1            replay is write
// - replay_data       in  WORD_W       replay payload
// - replay_id         in  MSHR_ADDR_W  replay MSHR slot
// - replay_ready      out 1            replay accepted (drives MSHR dequeue_ready)
// - fill_valid        in  1            memory fill response valid
// - fill_id           in  MSHR_ADDR_W  MSHR slot of the fill
// - fill_data         in  LINE_W       fill line data
// - fill_addr         in  LINE_ADDR_W  MSHR lookup of fill_id (combinational)
// - fill_ready        out 1            fill accepted; fill_valid&&fill_ready drives MSHR fill_valid
// - mshr_alm_full     in  1            blocks core grants when 1
// - pipe_valid        out 1            registered request to bank pipeline
// - pipe_sel          out 2            source: 0 = core, 1 = replay, 2 = fill; 3 never driven
// - pipe_addr         out LINE_ADDR_W  line address
// - pipe_rw           out 1            write flag; 0 for fill
// - pipe_data         out LINE_W       fill data, or word data zero-extended
// - pipe_id           out MSHR_ADDR_W  replay/fill slot; 0 for core
// - pipe_ready        in  1            bank pipeline accepts pipe_*
// BEHAVIOUR
// - Reset: pipe_valid = 0, pipe_sel/addr/rw/data/id = 0, starve counter = 0; all *_ready = 0 during reset.
// - Stall and capture:
//   - stall = pipe_valid && !pipe_ready.
//   - When !stall, the output register captures the grant winner: 1-cycle latency, full throughput.
//   - When stall, pipe_* hold stable and no *_ready is asserted.
// - Eligibility:
//   - fill: fill_valid.
//   - replay: replay_valid.
//   - core: core_req_valid && !mshr_alm_full.
// - Priority: fill > replay > core.
//   - Exception: starve counter == STARVE_MAX and core eligible -> core wins.
// - Starve counter:
//   - Increments (saturating at STARVE_MAX) on each non-stalled cycle where core is eligible and not granted.
//   - Clears when core is granted, or when core is not eligible.
//   - Holds during stall.
// - Exactly one *_ready per cycle, only for the winner; it is combinational from inputs and stall.
// - Fill -> replay ordering: a fill granted at cycle N makes MSHR dequeue_valid at N+1.
//   - Replay wins at N+1 unless another fill is valid.
//   - Back-to-back fills starve replay; the MSHR does not depend on replay progress for fill acceptance.
// - Simultaneous fill_valid and stall: fill_ready = 0; fill must be held (valid-stable) by source.
// - mshr_alm_full rising while core_req_valid: core_req_ready = 0 that cycle; the request stays pending.
// - Reset mid-operation clears the in-flight pipe request; the source re-presents it after reset.
// CONFIGURATION
// - CS_ARB_PERF_EN defined: adds output ports
//   - perf_core_stalls [PERF_CTR_W]: cycles with core_req_valid && !core_req_ready.
//   - perf_fills [PERF_CTR_W]: granted fills.
//   - perf_replays [PERF_CTR_W]: granted replays.
//   - All wrap modulo 2^PERF_CTR_W and reset to 0.
// - CS_ARB_PERF_EN undefined: no perf ports or counters; arbitration is identical.
// TESTING
// - Core only, addr=0x10, rw=0, pipe_ready=1 -> next cycle pipe_valid=1, sel=0, addr=0x10, id=0; 1 req/cycle sustained.
// - Fill id=2 + replay id=1 + core same cycle -> fill granted (sel=2, id=2, rw=0); replay next cycle; core third.
// - Core valid with 8 continuous fills, STARVE_MAX=8 -> core granted on 9th cycle; starve counter returns to 0.
// - pipe_ready=0 for 3 cycles with pipe_valid=1 -> pipe_* stable, all *_ready=0; resumes in the cycle pipe_ready=1.
// - mshr_alm_full=1 with core valid for 5 cycles -> no core grant; perf_core_stalls=5 (CS_ARB_PERF_EN).
// - reset asserted while pipe_valid=1 -> pipe_valid=0 next cycle; counters and starve count = 0.

Source files
------------

// File: rtl/cache_bank_input_arb.sv
// Cache bank input arbiter: fill > replay > core into one registered pipeline slot,
// with core starvation override. Define CS_ARB_PERF_EN to add perf counter ports.
module cache_bank_input_arb #(
  parameter int LINE_ADDR_W = 26,
  parameter int WORD_W      = 32,
  parameter int LINE_W      = 512,
  parameter int MSHR_ADDR_W = 2,
  parameter int STARVE_MAX  = 8,
  parameter int PERF_CTR_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   core_req_valid,
  input  logic [LINE_ADDR_W-1:0] core_req_addr,
  input  logic                   core_req_rw,
  input  logic [WORD_W-1:0]      core_req_data,
  output logic                   core_req_ready,
  input  logic                   replay_valid,
  input  logic [LINE_ADDR_W-1:0] replay_addr,
  input  logic                   replay_rw,
  input  logic [WORD_W-1:0]      replay_data,
  input  logic [MSHR_ADDR_W-1:0] replay_id,
  output logic                   replay_ready,
  input  logic                   fill_valid,
  input  logic [MSHR_ADDR_W-1:0] fill_id,
  input  logic [LINE_W-1:0]      fill_data,
  input  logic [LINE_ADDR_W-1:0] fill_addr,
  output logic                   fill_ready,
  input  logic                   mshr_alm_full,
  output logic                   pipe_valid,
  output logic [1:0]             pipe_sel,
  output logic [LINE_ADDR_W-1:0] pipe_addr,
  output logic                   pipe_rw,
  output logic [LINE_W-1:0]      pipe_data,
  output logic [MSHR_ADDR_W-1:0] pipe_id,
  input  logic                   pipe_ready
`ifdef CS_ARB_PERF_EN
  ,
  output logic [PERF_CTR_W-1:0]  perf_core_stalls,
  output logic [PERF_CTR_W-1:0]  perf_fills,
  output logic [PERF_CTR_W-1:0]  perf_replays
`endif
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  logic                   stall_s;
  logic                   core_elig_s;
  logic                   force_core_s;
  logic                   grant_core_s;
  logic                   grant_replay_s;
  logic                   grant_fill_s;
  logic [STARVE_W-1:0]    starve_r;
  logic                   nxt_valid_s;
  logic [1:0]             nxt_sel_s;
  logic [LINE_ADDR_W-1:0] nxt_addr_s;
  logic                   nxt_rw_s;
  logic [LINE_W-1:0]      nxt_data_s;
  logic [MSHR_ADDR_W-1:0] nxt_id_s;

  assign stall_s      = pipe_valid && !pipe_ready;
  assign core_elig_s  = core_req_valid && !mshr_alm_full;
  assign force_core_s = core_elig_s && (starve_r == STARVE_W'(STARVE_MAX));

  // Priority select; the starvation override lets core jump ahead of fill and replay
  always_comb begin
    grant_core_s   = 1'b0;
    grant_replay_s = 1'b0;
    grant_fill_s   = 1'b0;
    if (force_core_s) begin
      grant_core_s = 1'b1;
    end else if (fill_valid) begin
      grant_fill_s = 1'b1;
    end else if (replay_valid) begin
      grant_replay_s = 1'b1;
    end else if (core_elig_s) begin
      grant_core_s = 1'b1;
    end else begin
      grant_core_s = 1'b0;
    end
  end

  assign core_req_ready = grant_core_s   && !stall_s && !reset;
  assign replay_ready   = grant_replay_s && !stall_s && !reset;
  assign fill_ready     = grant_fill_s   && !stall_s && !reset;

  // Winner payload mux feeding the output register
  always_comb begin
    nxt_valid_s = 1'b0;
    nxt_sel_s   = 2'd0;
    nxt_addr_s  = '0;
    nxt_rw_s    = 1'b0;
    nxt_data_s  = '0;
    nxt_id_s    = '0;
    if (grant_fill_s) begin
      nxt_valid_s = 1'b1;
      nxt_sel_s   = 2'd2;
      nxt_addr_s  = fill_addr;
      nxt_data_s  = fill_data;
      nxt_id_s    = fill_id;
    end else if (grant_replay_s) begin
      nxt_valid_s = 1'b1;
      nxt_sel_s   = 2'd1;
      nxt_addr_s  = replay_addr;
      nxt_rw_s    = replay_rw;
      nxt_data_s  = LINE_W'(replay_data);
      nxt_id_s    = replay_id;
    end else if (grant_core_s) begin
      nxt_valid_s = 1'b1;
      nxt_sel_s   = 2'd0;
      nxt_addr_s  = core_req_addr;
      nxt_rw_s    = core_req_rw;
      nxt_data_s  = LINE_W'(core_req_data);
    end else begin
      nxt_valid_s = 1'b0;
    end
  end

  // Output register: captures the winner unless the pipeline is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= 1'b0;
      pipe_sel   <= 2'd0;
      pipe_addr  <= '0;
      pipe_rw    <= 1'b0;
      pipe_data  <= '0;
      pipe_id    <= '0;
    end else if (!stall_s) begin
      pipe_valid <= nxt_valid_s;
      pipe_sel   <= nxt_sel_s;
      pipe_addr  <= nxt_addr_s;
      pipe_rw    <= nxt_rw_s;
      pipe_data  <= nxt_data_s;
      pipe_id    <= nxt_id_s;
    end
  end

  // Starvation counter: counts eligible-but-denied core cycles, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_r <= '0;
    end else if (!stall_s) begin
      if (core_elig_s && !grant_core_s) begin
        if (starve_r != STARVE_W'(STARVE_MAX)) begin
          starve_r <= starve_r + STARVE_W'(1);
        end
      end else begin
        starve_r <= '0;
      end
    end
  end

`ifdef CS_ARB_PERF_EN
  // Free-running wrap-around event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_core_stalls <= '0;
      perf_fills       <= '0;
      perf_replays     <= '0;
    end else begin
      if (core_req_valid && !core_req_ready) begin
        perf_core_stalls <= perf_core_stalls + PERF_CTR_W'(1);
      end
      if (fill_valid && fill_ready) begin
        perf_fills <= perf_fills + PERF_CTR_W'(1);
      end
      if (replay_valid && replay_ready) begin
        perf_replays <= perf_replays + PERF_CTR_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_bank_input_arb.sv
// Randomized and directed bench for cache_bank_input_arb against a cycle-level reference model.
module tb_cache_bank_input_arb;
  localparam int LA = 26;
  localparam int WW = 32;
  localparam int LW = 512;
  localparam int MW = 2;
  localparam int SM = 8;
  localparam int PW = 32;

  logic          clk;
  logic          reset;
  logic          core_req_valid;
  logic [LA-1:0] core_req_addr;
  logic          core_req_rw;
  logic [WW-1:0] core_req_data;
  logic          core_req_ready;
  logic          replay_valid;
  logic [LA-1:0] replay_addr;
  logic          replay_rw;
  logic [WW-1:0] replay_data;
  logic [MW-1:0] replay_id;
  logic          replay_ready;
  logic          fill_valid;
  logic [MW-1:0] fill_id;
  logic [LW-1:0] fill_data;
  logic [LA-1:0] fill_addr;
  logic          fill_ready;
  logic          mshr_alm_full;
  logic          pipe_valid;
  logic [1:0]    pipe_sel;
  logic [LA-1:0] pipe_addr;
  logic          pipe_rw;
  logic [LW-1:0] pipe_data;
  logic [MW-1:0] pipe_id;
  logic          pipe_ready;
`ifdef CS_ARB_PERF_EN
  logic [PW-1:0] perf_core_stalls;
  logic [PW-1:0] perf_fills;
  logic [PW-1:0] perf_replays;
`endif

  cache_bank_input_arb #(
    .LINE_ADDR_W(LA), .WORD_W(WW), .LINE_W(LW), .MSHR_ADDR_W(MW),
    .STARVE_MAX(SM), .PERF_CTR_W(PW)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_addr(core_req_addr),
    .core_req_rw(core_req_rw), .core_req_data(core_req_data),
    .core_req_ready(core_req_ready),
    .replay_valid(replay_valid), .replay_addr(replay_addr), .replay_rw(replay_rw),
    .replay_data(replay_data), .replay_id(replay_id), .replay_ready(replay_ready),
    .fill_valid(fill_valid), .fill_id(fill_id), .fill_data(fill_data),
    .fill_addr(fill_addr), .fill_ready(fill_ready),
    .mshr_alm_full(mshr_alm_full),
    .pipe_valid(pipe_valid), .pipe_sel(pipe_sel), .pipe_addr(pipe_addr),
    .pipe_rw(pipe_rw), .pipe_data(pipe_data), .pipe_id(pipe_id),
    .pipe_ready(pipe_ready)
`ifdef CS_ARB_PERF_EN
    ,
    .perf_core_stalls(perf_core_stalls), .perf_fills(perf_fills),
    .perf_replays(perf_replays)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: the request currently held for the pipeline, starvation count, perf totals
  logic          m_valid = 1'b0;
  logic [1:0]    m_sel   = 2'd0;
  logic [LA-1:0] m_addr  = '0;
  logic          m_rw    = 1'b0;
  logic [LW-1:0] m_data  = '0;
  logic [MW-1:0] m_id    = '0;
  int            m_starve = 0;
  logic [PW-1:0] m_pcs = '0;
  logic [PW-1:0] m_pf  = '0;
  logic [PW-1:0] m_pr  = '0;

  task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: inputs already applied; check readies, advance model, check registered outputs
  task automatic step();
    bit stall, core_el;
    int w;
    logic n_valid; logic [1:0] n_sel; logic [LA-1:0] n_addr; logic n_rw;
    logic [LW-1:0] n_data; logic [MW-1:0] n_id;
    int n_starve;
    #1;
    stall   = m_valid && !pipe_ready;
    core_el = core_req_valid && !mshr_alm_full;
    w = -1;
    if (!reset && !stall) begin
      if (core_el && m_starve == SM) w = 0;
      else if (fill_valid) w = 2;
      else if (replay_valid) w = 1;
      else if (core_el) w = 0;
    end
    check_val("core_ready",   LW'(core_req_ready), LW'(w == 0));
    check_val("replay_ready", LW'(replay_ready),   LW'(w == 1));
    check_val("fill_ready",   LW'(fill_ready),     LW'(w == 2));

    n_valid = m_valid; n_sel = m_sel; n_addr = m_addr; n_rw = m_rw;
    n_data = m_data; n_id = m_id; n_starve = m_starve;
    if (reset) begin
      n_valid = 1'b0; n_sel = 2'd0; n_addr = '0; n_rw = 1'b0; n_data = '0; n_id = '0;
      n_starve = 0;
    end else if (!stall) begin
      n_valid = (w >= 0); n_sel = 2'd0; n_addr = '0; n_rw = 1'b0; n_data = '0; n_id = '0;
      case (w)
        0: begin n_addr = core_req_addr; n_rw = core_req_rw; n_data = LW'(core_req_data); end
        1: begin n_sel = 2'd1; n_addr = replay_addr; n_rw = replay_rw;
                 n_data = LW'(replay_data); n_id = replay_id; end
        2: begin n_sel = 2'd2; n_addr = fill_addr; n_data = fill_data; n_id = fill_id; end
        default: n_valid = 1'b0;
      endcase
      if (core_el && w != 0) n_starve = (m_starve < SM) ? m_starve + 1 : SM;
      else n_starve = 0;
    end
    if (reset) begin
      m_pcs = '0; m_pf = '0; m_pr = '0;
    end else begin
      if (core_req_valid && w != 0) m_pcs = m_pcs + PW'(1);
      if (w == 2) m_pf = m_pf + PW'(1);
      if (w == 1) m_pr = m_pr + PW'(1);
    end

    @(posedge clk);
    #1;
    m_valid = n_valid; m_sel = n_sel; m_addr = n_addr; m_rw = n_rw;
    m_data = n_data; m_id = n_id; m_starve = n_starve;
    check_val("pipe_valid", LW'(pipe_valid), LW'(m_valid));
    check_val("pipe_sel",   LW'(pipe_sel),   LW'(m_sel));
    check_val("pipe_addr",  LW'(pipe_addr),  LW'(m_addr));
    check_val("pipe_rw",    LW'(pipe_rw),    LW'(m_rw));
    check_val("pipe_data",  pipe_data,       m_data);
    check_val("pipe_id",    LW'(pipe_id),    LW'(m_id));
`ifdef CS_ARB_PERF_EN
    check_val("perf_core_stalls", LW'(perf_core_stalls), LW'(m_pcs));
    check_val("perf_fills",       LW'(perf_fills),       LW'(m_pf));
    check_val("perf_replays",     LW'(perf_replays),     LW'(m_pr));
`endif
  endtask

  task automatic idle_inputs();
    core_req_valid = 1'b0; core_req_addr = '0; core_req_rw = 1'b0; core_req_data = '0;
    replay_valid = 1'b0; replay_addr = '0; replay_rw = 1'b0; replay_data = '0; replay_id = '0;
    fill_valid = 1'b0; fill_id = '0; fill_data = '0; fill_addr = '0;
    mshr_alm_full = 1'b0; pipe_ready = 1'b1;
  endtask

  initial begin
    logic [LA-1:0] held_addr;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    check_val("reset_valid", LW'(pipe_valid), LW'(1'b0));
    reset = 1'b0;
    step();

    // Core only, sustained one per cycle
    core_req_valid = 1'b1; core_req_addr = LA'(32'h10); core_req_data = 32'hCAFE_0001;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("core_stream_sel", LW'({pipe_valid, pipe_sel, pipe_id}),
                LW'({1'b1, 2'd0, 2'd0}));
      check_val("core_stream_addr", LW'(pipe_addr), LW'(32'h10));
    end
    idle_inputs();
    step();

    // Fill, replay and core together: fill, then replay, then core
    fill_valid = 1'b1; fill_id = 2'd2; fill_addr = LA'(32'h123); fill_data = rnd_line();
    replay_valid = 1'b1; replay_id = 2'd1; replay_addr = LA'(32'h456); replay_rw = 1'b1;
    replay_data = 32'h1234_5678;
    core_req_valid = 1'b1; core_req_addr = LA'(32'h789);
    step();
    check_val("triple_fill", LW'({pipe_sel, pipe_id, pipe_rw}), LW'({2'd2, 2'd2, 1'b0}));
    fill_valid = 1'b0;
    step();
    check_val("triple_replay", LW'({pipe_sel, pipe_id}), LW'({2'd1, 2'd1}));
    replay_valid = 1'b0;
    step();
    check_val("triple_core", LW'({pipe_valid, pipe_sel}), LW'({1'b1, 2'd0}));
    idle_inputs();
    step();

    // Continuous fills starve core until the override fires on the 9th cycle
    core_req_valid = 1'b1; core_req_addr = LA'(32'h55);
    fill_valid = 1'b1; fill_id = 2'd3; fill_addr = LA'(32'h66);
    for (int i = 0; i < SM; i++) begin
      fill_data = rnd_line();
      step();
      check_val("starve_fill", LW'(pipe_sel), LW'(2'd2));
    end
    step();
    check_val("starve_core", LW'({pipe_valid, pipe_sel}), LW'({1'b1, 2'd0}));
    step();
    check_val("starve_cleared", LW'(pipe_sel), LW'(2'd2));
    idle_inputs();
    step();

    // Pipeline stall: held request stays stable, no readies
    core_req_valid = 1'b1; core_req_addr = LA'(32'hABC);
    step();
    held_addr = pipe_addr;
    pipe_ready = 1'b0; core_req_addr = LA'(32'hDEF); fill_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_hold", LW'(pipe_addr), LW'(held_addr));
    end
    pipe_ready = 1'b1;
    step();
    check_val("stall_resume", LW'(pipe_sel), LW'(2'd2));
    idle_inputs();
    step();

    // MSHR almost full blocks core
    core_req_valid = 1'b1; mshr_alm_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("almfull_block", LW'(pipe_valid), LW'(1'b0));
    end
    idle_inputs();
    step();

    // Reset while a request is in flight
    core_req_valid = 1'b1; pipe_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    check_val("midreset_valid", LW'(pipe_valid), LW'(1'b0));
    reset = 1'b0; idle_inputs();
    step();

    // Randomized traffic, with occasional fill-heavy phases to exercise starvation
    for (int i = 0; i < 3000; i++) begin
      bit heavy;
      heavy = ((i / 200) % 3) == 2;
      reset          = ($urandom_range(0, 199) == 0);
      core_req_valid = $urandom_range(0, 1);
      core_req_addr  = LA'($urandom);
      core_req_rw    = $urandom_range(0, 1);
      core_req_data  = $urandom;
      replay_valid   = $urandom_range(0, 1);
      replay_addr    = LA'($urandom);
      replay_rw      = $urandom_range(0, 1);
      replay_data    = $urandom;
      replay_id      = MW'($urandom);
      fill_valid     = heavy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
      fill_id        = MW'($urandom);
      fill_addr      = LA'($urandom);
      fill_data      = rnd_line();
      mshr_alm_full  = ($urandom_range(0, 3) == 0);
      pipe_ready     = heavy ? 1'b1 : ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
